// File: rtl/tag_responder_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tag_responder_resolver
// Purpose  : Captures a search tag vector and reports each responder index,
//            lowest first, over valid/ready, scanning one segment per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tag_responder_resolver #(
    parameter int N_CELLS = 4096,
    parameter int SEG_W   = 32,
    parameter int IDX_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CELLS-1:0] tag_in,
    input  logic               load,
    input  logic               abort,
    output logic               idle,
    output logic               some,
    output logic               resp_valid,
    output logic [IDX_W-1:0]   resp_index,
    input  logic               resp_ready,
    output logic               done,
    output logic [IDX_W:0]     resp_count
);

    localparam int c_SEG_LOG   = $clog2(SEG_W);
    localparam int c_N_SEG     = N_CELLS / SEG_W;
    localparam int c_SEG_PTR_W = IDX_W - c_SEG_LOG;
    localparam logic [c_SEG_PTR_W-1:0] c_LAST_SEG = c_SEG_PTR_W'(c_N_SEG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [N_CELLS-1:0]       r_tag;
    logic [c_SEG_PTR_W-1:0]   r_seg_ptr;
    logic                     r_some;
    logic                     r_resp_valid;
    logic [IDX_W-1:0]         r_resp_index;
    logic [IDX_W:0]           r_resp_count;

    logic [IDX_W-1:0]         w_seg_base;
    logic [SEG_W-1:0]         w_seg;
    logic [c_SEG_LOG-1:0]     w_low_pos;
    logic                     w_seg_hit;
    logic                     w_last_seg;

    assign w_seg_base = {r_seg_ptr, {c_SEG_LOG{1'b0}}};
    assign w_seg      = r_tag[w_seg_base +: SEG_W];
    assign w_seg_hit  = |w_seg;
    assign w_last_seg = (r_seg_ptr == c_LAST_SEG);

    // Descending loop so the lowest set bit is the last one written.
    always_comb begin
        w_low_pos = '0;
        for (int i = SEG_W - 1; i >= 0; i--) begin
            if (w_seg[i]) begin
                w_low_pos = c_SEG_LOG'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (load) w_state_nxt = S_SCAN;
            S_SCAN: begin
                if (abort)           w_state_nxt = S_IDLE;
                else if (w_seg_hit)  w_state_nxt = S_EMIT;
                else if (w_last_seg) w_state_nxt = S_DONE;
            end
            S_EMIT: begin
                if (abort)           w_state_nxt = S_IDLE;
                else if (resp_ready) w_state_nxt = S_SCAN;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag        <= '0;
            r_seg_ptr    <= '0;
            r_some       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_index <= '0;
            r_resp_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_tag        <= tag_in;
                        r_some       <= |tag_in;
                        r_seg_ptr    <= '0;
                        r_resp_count <= '0;
                    end
                end
                S_SCAN: begin
                    if (!abort) begin
                        if (w_seg_hit) begin
                            r_resp_index <= w_seg_base | IDX_W'(w_low_pos);
                            r_resp_valid <= 1'b1;
                        end else if (!w_last_seg) begin
                            r_seg_ptr <= r_seg_ptr + c_SEG_PTR_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    // Abort wins over a same-cycle handshake; that responder is not counted.
                    if (abort) begin
                        r_resp_valid <= 1'b0;
                    end else if (resp_ready) begin
                        r_tag[r_resp_index] <= 1'b0;
                        r_resp_count        <= r_resp_count + (IDX_W+1)'(1);
                        r_resp_valid        <= 1'b0;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign idle       = (r_state == S_IDLE);
    assign done       = (r_state == S_DONE);
    assign some       = r_some;
    assign resp_valid = r_resp_valid;
    assign resp_index = r_resp_index;
    assign resp_count = r_resp_count;

endmodule
`default_nettype wire

// File: tb/tb_tag_responder_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_tag_responder_resolver
// Purpose  : Scoreboard bench for tag_responder_resolver with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tag_responder_resolver;

    localparam int N_CELLS = 4096;
    localparam int SEG_W   = 32;
    localparam int IDX_W   = 12;

    logic               clk;
    logic               rst_n;
    logic [N_CELLS-1:0] tag_in;
    logic               load;
    logic               abort;
    logic               idle;
    logic               some;
    logic               resp_valid;
    logic [IDX_W-1:0]   resp_index;
    logic               resp_ready;
    logic               done;
    logic [IDX_W:0]     resp_count;

    tag_responder_resolver #(
        .N_CELLS (N_CELLS),
        .SEG_W   (SEG_W),
        .IDX_W   (IDX_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tag_in     (tag_in),
        .load       (load),
        .abort      (abort),
        .idle       (idle),
        .some       (some),
        .resp_valid (resp_valid),
        .resp_index (resp_index),
        .resp_ready (resp_ready),
        .done       (done),
        .resp_count (resp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit valid_seen = 0;
    int exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready && !abort) begin
            if (exp_q.size() == 0) begin
                check("unexpected_responder", 32'(resp_index), 32'hFFFF_FFFF);
            end else begin
                check("responder_index", 32'(resp_index), 32'(exp_q.pop_front()));
            end
        end
        if (done) done_cnt++;
        if (resp_valid) valid_seen = 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_load(input logic [N_CELLS-1:0] v);
        tag_in = v;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        cyc    = 1;
    endtask

    task automatic wait_done(input int limit, input string name);
        int n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input int limit, input string name);
        int n = 0;
        while (!resp_valid && n < limit) begin
            tick();
            n++;
        end
        check(name, 32'(resp_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N_CELLS-1:0] v;
        int d0;

        rst_n      = 1'b0;
        tag_in     = '0;
        load       = 1'b0;
        abort      = 1'b0;
        resp_ready = 1'b0;
        tick();
        tick();
        check("rst_idle",       32'(idle),       32'd1);
        check("rst_some",       32'(some),       32'd0);
        check("rst_valid",      32'(resp_valid), 32'd0);
        check("rst_index",      32'(resp_index), 32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_count",      32'(resp_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Empty search
        d0 = done_cnt;
        valid_seen = 0;
        do_load('0);
        repeat (127) tick();
        check("empty_done_c128", 32'(done), 32'd0);
        tick();
        check("empty_done_c129", 32'(done), 32'd1);
        check("empty_some",      32'(some), 32'd0);
        check("empty_count",     32'(resp_count), 32'd0);
        tick();
        check("empty_idle_c130", 32'(idle), 32'd1);
        check("empty_no_valid",  32'(valid_seen), 32'd0);
        check("empty_done_once", 32'(done_cnt - d0), 32'd1);

        // Single responder
        resp_ready = 1'b1;
        v = '0; v[5] = 1'b1;
        exp_q.push_back(5);
        do_load(v);
        check("single_valid_c1", 32'(resp_valid), 32'd0);
        tick();
        check("single_valid_c2", 32'(resp_valid), 32'd1);
        check("single_index_c2", 32'(resp_index), 32'd5);
        wait_done(300, "single_done");
        check("single_done_cycle", 32'(cyc), 32'd131);
        check("single_count", 32'(resp_count), 32'd1);
        check("single_some",  32'(some), 32'd1);
        tick();

        // Ordering across segments
        d0 = done_cnt;
        v = '0; v[0] = 1'b1; v[31] = 1'b1; v[32] = 1'b1; v[4095] = 1'b1;
        exp_q.push_back(0); exp_q.push_back(31); exp_q.push_back(32); exp_q.push_back(4095);
        do_load(v);
        wait_done(400, "order_done");
        check("order_count", 32'(resp_count), 32'd4);
        repeat (4) tick();
        check("order_done_once", 32'(done_cnt - d0), 32'd1);
        check("order_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure
        resp_ready = 1'b0;
        v = '0; v[7] = 1'b1; v[9] = 1'b1;
        exp_q.push_back(7); exp_q.push_back(9);
        do_load(v);
        wait_valid(20, "bp_valid");
        for (int i = 0; i < 10; i++) begin
            check("bp_stall_index", 32'(resp_index), 32'd7);
            check("bp_stall_valid", 32'(resp_valid), 32'd1);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check("bp_gap_valid", 32'(resp_valid), 32'd0);
        tick();
        check("bp_next_valid", 32'(resp_valid), 32'd1);
        check("bp_next_index", 32'(resp_index), 32'd9);
        wait_done(300, "bp_done");
        check("bp_count", 32'(resp_count), 32'd2);
        tick();

        // Abort on the same cycle as the handshake
        resp_ready = 1'b0;
        d0 = done_cnt;
        v = '0; v[3] = 1'b1; v[100] = 1'b1;
        do_load(v);
        wait_valid(20, "abort_valid");
        check("abort_index", 32'(resp_index), 32'd3);
        resp_ready = 1'b1;
        abort      = 1'b1;
        tick();
        abort      = 1'b0;
        resp_ready = 1'b0;
        check("abort_idle",  32'(idle),       32'd1);
        check("abort_valid_low", 32'(resp_valid), 32'd0);
        check("abort_count", 32'(resp_count), 32'd0);
        check("abort_some",  32'(some),       32'd1);
        repeat (3) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        resp_ready = 1'b1;
        v = '0; v[10] = 1'b1;
        exp_q.push_back(10);
        do_load(v);
        wait_valid(20, "reload_valid");
        check("reload_index", 32'(resp_index), 32'd10);
        wait_done(300, "reload_done");
        check("reload_count", 32'(resp_count), 32'd1);
        tick();

        // Asynchronous reset during EMIT
        resp_ready = 1'b0;
        v = '0; v[7] = 1'b1;
        do_load(v);
        wait_valid(20, "arst_valid");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid_low", 32'(resp_valid), 32'd0);
        check("arst_index",     32'(resp_index), 32'd0);
        check("arst_idle",      32'(idle),       32'd1);
        check("arst_some",      32'(some),       32'd0);
        check("arst_count",     32'(resp_count), 32'd0);
        check("arst_done",      32'(done),       32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // load during SCAN must be ignored
        resp_ready = 1'b1;
        v = '0; v[40] = 1'b1;
        exp_q.push_back(40);
        do_load(v);
        v = '0; v[2] = 1'b1;
        tag_in = v;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        wait_done(300, "scanload_done");
        check("scanload_count", 32'(resp_count), 32'd1);
        tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tag_responder_resolver.md
# tag_responder_resolver

Multiple-response resolver that sits directly downstream of the CAPP compare/tag stage. It captures the full tag vector produced by a search, then reports every responding cell index one at a time, lowest index first, over a valid/ready handshake. It also reports the some/none status of the search and a count of the responders it delivered. The vector is scanned one segment per cycle, which keeps the priority-encode path short at 4096 cells.

## Interface
- N_CELLS, 4096: number of tag bits (cells); must be a multiple of SEG_W
- SEG_W, 32: segment width examined per cycle; power of two
- IDX_W, 12: cell index width, equal to log2(N_CELLS)
- CLK  in  1  system clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- tag_in  in  N_CELLS  tag vector from the compare stage; bit i set means cell i responded
- load  in  1  capture tag_in; honoured only in IDLE
- abort  in  1  drop the current resolution and return to IDLE
- idle  out  1  high in IDLE, meaning the block will accept load
- some  out  1  registered OR of the last captured tag vector
- resp_valid  out  1  resp_index holds a valid responder
- resp_index  out  IDX_W  index of the current responder
- resp_ready  in  1  consumer accepts resp_index
- done  out  1  one-cycle pulse when all responders have been delivered
- resp_count  out  IDX_W+1  responders delivered since the last load

## Operation
- Holding registers:
  - tag_reg[N_CELLS]
  - seg_ptr, range 0..N_CELLS/SEG_W-1
  - state: IDLE, SCAN, EMIT, DONE
- **Reset** (RST_N low, asynchronous):
  - state=IDLE, tag_reg=0, seg_ptr=0
  - idle=1, some=0, resp_valid=0, resp_index=0, done=0, resp_count=0
- **IDLE**:
  - On load=1: tag_reg←tag_in, some←|tag_in, seg_ptr←0, resp_count←0, go to SCAN.
  - load is ignored in every other state.
- **SCAN**: take the segment seg = tag_reg[seg_ptr*SEG_W +: SEG_W].
  - seg≠0: resp_index←seg_ptr*SEG_W + position of lowest set bit, resp_valid←1, go to EMIT.
  - seg=0 and seg_ptr is the last segment: go to DONE.
  - seg=0 otherwise: seg_ptr←seg_ptr+1.
- **EMIT**:
  - resp_valid and resp_index stay stable until resp_valid&&resp_ready.
  - On handshake: clear tag_reg[resp_index], resp_count←resp_count+1, resp_valid←0, go to SCAN. seg_ptr is unchanged, so the same segment is rescanned.
- **DONE**: done=1 for exactly this cycle, then go to IDLE.
- **abort**, in any non-IDLE state:
  - Next state is IDLE and resp_valid←0.
  - done is not pulsed.
  - some and resp_count keep their values.
  - abort has priority over the handshake in the same cycle; that responder is not counted.
- some is set only at load and holds until the next load or reset.
- resp_count saturates naturally: it reaches at most N_CELLS (4096) and needs IDX_W+1 bits.
- idle is combinational on state==IDLE.

## Timing
- Cycle n below means the clock cycle following the n-th rising edge after load is sampled (load sampled at edge 0).
- First SCAN happens in cycle 1, covering segment 0.
- When the first nonzero segment is k, resp_valid rises in cycle 2+k.
- Handshake in cycle e gives SCAN in e+1 and the next resp_valid at e+2 at the earliest. Within one segment, the best rate is one responder per 2 cycles.
- Empty segments cost one cycle each.
- When no bits are set:
  - DONE falls in cycle N_CELLS/SEG_W+1 (129 at defaults).
  - idle returns in cycle 130.
- Worst-case total is (N_CELLS/SEG_W) + 2×responders + 1 cycles, plus any consumer stall.
- resp_index must not change while resp_valid=1 and resp_ready=0.

## Test plan
- **Empty search**: load with tag_in=0, abort=0.
  - some=0, resp_valid never rises, done pulses in cycle 129, resp_count=0, idle=1 in cycle 130.
- **Single responder**: tag_in bit 5 only, resp_ready=1.
  - resp_valid=1 with resp_index=5 in cycle 2, done in cycle 131, resp_count=1, some=1.
- **Ordering across segments**: bits {0, 31, 32, 4095}, resp_ready=1.
  - Indices appear in the order 0, 31, 32, 4095, resp_count=4, then exactly one done pulse.
- **Backpressure**: bits {7, 9}, resp_ready held low for 10 cycles after resp_valid rises.
  - resp_index stays 7 throughout the stall.
  - After ready rises, the next responder is 9 two cycles later.
- **Abort**: bits {3, 100}, abort asserted in the same cycle as the handshake on 3.
  - IDLE next cycle, resp_valid=0, no done pulse, resp_count=0.
  - A new load with bit 10 then yields resp_index=10.
- **Reset mid-operation, and load outside IDLE**:
  - RST_N low during EMIT: all outputs return to reset values immediately, without waiting for a clock edge.
  - load pulsed during SCAN: ignored, and tag_reg is unchanged.
